afifo_wr_arb: RTL and testbench
===============================

// Module: afifo_wr_arb
// PURPOSE
//  Write-side arbiter for the async FIFO: shares a single FIFO write port among
//  NREQ requesters in the write clock domain using a round-robin policy.
//  Each requester has a valid/ready handshake. The arbiter drives wen/wdata
//  straight into the FIFO write port and backs off on the FIFO's write-domain full.
// PARAMETERS
//  DSIZE      8  data width; must match the FIFO DSIZE
//  NREQ       4  number of requesters, 2..16
//  MAX_BURST  4  beats per grant when AFIFO_WR_ARB_BURST_EN is defined, 1..255
// PORTS
//  clk          in   1           write-domain clock (FIFO wclk)
//  rst_n        in   1           asynchronous active-low reset (FIFO wrst_n)
//  req_valid    in   NREQ        requester i has a beat pending
//  req_data     in   NREQ*DSIZE  requester i data at bits [i*DSIZE +: DSIZE]
//  req_ready    out  NREQ        beat of requester i accepted this cycle
//  fifo_full    in   1           FIFO full, write-clock domain
//  fifo_wen     out  1           FIFO write enable
//  fifo_wdata   out  DSIZE       FIFO write data
//  grant_valid  out  1           a requester currently holds the grant
//  grant_id     out  clog2(NREQ) index of the granted requester
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, grant_valid=0, grant_id=0, beat_cnt=0,
//    last=NREQ-1 (requester 0 has first priority). req_ready=0, fifo_wen=0.
//  - Handshake: a beat transfers when req_valid[i] & req_ready[i].
//    Requesters hold valid and data stable until accepted. Valid must not depend on ready.
//  - req_ready[i] = grant_valid & (grant_id==i) & ~fifo_full. Combinational, zero latency.
//    fifo_wen = |(req_valid & req_ready); fifo_wdata = req_data[grant_id].
//  - Writes are never issued while fifo_full=1, so no FIFO overrun is possible.
//  - FSM:
//    IDLE:  if |req_valid, register grant_id = rr_pick(req_valid, last),
//           set beat_cnt=0 and go to GRANT. This first grant costs one bubble cycle.
//    GRANT: a transfer increments beat_cnt.
//           The grant is released at the clock edge when either:
//             (a) req_valid[grant_id]=0, or
//             (b) a transfer occurs with beat_cnt==LIMIT-1.
//           On release: last = grant_id.
//             If another requester is valid, re-grant at the same edge
//             (search starts after last, no bubble) and stay in GRANT.
//             Otherwise go to IDLE.
//           In case (b), if the only valid requester is the current one,
//           it is re-granted with beat_cnt=0.
//  - fifo_full during GRANT: grant is held, beat_cnt frozen, no timeout.
//    If valid drops while full, rule (a) releases the grant.
//  - beat_cnt width is clog2(MAX_BURST+1) bits; it never wraps past LIMIT-1.
//  - rst_n asserted mid-burst: immediate return to the reset state.
//    Any in-flight un-accepted beat stays with its requester.
// CONFIGURATION
//  AFIFO_WR_ARB_BURST_EN defined:   LIMIT=MAX_BURST. A granted requester keeps
//                                   the port for up to MAX_BURST consecutive beats.
//  AFIFO_WR_ARB_BURST_EN undefined: LIMIT=1. The grant rotates after every
//                                   beat; MAX_BURST is ignored.
// STRUCTURE
//  - afifo_pkg: FIFO DSIZE/ASIZE defaults, the arbiter state enum {IDLE,GRANT},
//    and the clog2 helper function.
//  - Sub-module rr_pick: combinational rotate-priority-encoder.
//    Inputs: NREQ-bit request vector and last index. Outputs: next index, any.
//  - The top level holds the FSM, beat counter, last pointer and output mux.
// TESTING  (DSIZE=8, NREQ=4, MAX_BURST=4)
//  1. Reset, then req_valid=4'b0010 with data 0x5A
//     -> grant_valid=1, grant_id=1 one cycle later;
//        fifo_wen=1 with fifo_wdata=0x5A that cycle; IDLE after valid drops.
//  2. BURST_EN off; all 4 valid continuously with fifo_full=0
//     -> grant_id sequence 0,1,2,3,0,...; fifo_wen=1 every cycle after the
//        first bubble; each beat's data matches its requester.
//  3. BURST_EN on; req 0 and 2 valid continuously
//     -> 4 beats from 0, then 4 beats from 2, then 0 again, with no bubble
//        between bursts.
//  4. Granted to 1; fifo_full=1 for 5 cycles
//     -> req_ready=0 and fifo_wen=0 throughout; grant_id stays 1;
//        the held beat is written on the first cycle after full drops.
//  5. BURST_EN on; req 3 drops valid after 2 of 4 beats while req 1 is valid
//     -> grant moves to 1 at the next edge; req 3 gets no further grant.
//  6. rst_n pulsed low mid-burst
//     -> all outputs 0 asynchronously; on release with all valid, grant goes
//        to 0 first.

Source files
------------

// File: rtl/afifo_pkg.sv
// afifo_pkg: shared FIFO defaults, write-arbiter state encoding and clog2 helper.
package afifo_pkg;
    localparam int FIFO_DSIZE = 8;
    localparam int FIFO_ASIZE = 4;
    typedef enum logic {IDLE, GRANT} arb_state_t;
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/afifo_wr_arb_rr_pick.sv
// rr_pick: rotate-priority encoder; returns the first set request strictly after
// i_last, wrapping around so i_last itself has the lowest priority.
module rr_pick
    import afifo_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % NREQ]) begin
                o_idx = IW'((int'(i_last) + k) % NREQ);
                o_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/afifo_wr_arb.sv
// afifo_wr_arb: round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// Define AFIFO_WR_ARB_BURST_EN to let a grant hold the port for up to MAX_BURST beats.
module afifo_wr_arb
    import afifo_pkg::*;
#(
    parameter  int DSIZE     = FIFO_DSIZE,
    parameter  int NREQ      = 4,
    parameter  int MAX_BURST = 4,
    localparam int IW        = clog2(NREQ),
    localparam int BW        = clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wen,
    output logic [DSIZE-1:0]      fifo_wdata,
    output logic                  grant_valid,
    output logic [IW-1:0]         grant_id
);
`ifdef AFIFO_WR_ARB_BURST_EN
    localparam int LIMIT = MAX_BURST;
`else
    localparam int LIMIT = 1;
`endif

    arb_state_t    r_state, w_state_nxt;
    logic [IW-1:0] r_grant_id, w_grant_id_nxt, r_last, w_last_nxt, w_pick_idx;
    logic [BW-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic          w_pick_any, w_release;

    assign grant_valid = (r_state == GRANT);
    assign grant_id    = r_grant_id;
    assign req_ready   = (grant_valid && !fifo_full) ? (NREQ'(1) << r_grant_id) : '0;
    assign fifo_wen    = |(req_valid & req_ready);
    assign fifo_wdata  = req_data[r_grant_id*DSIZE +: DSIZE];
    assign w_release   = grant_valid &&
                         (!req_valid[r_grant_id] || (fifo_wen && r_beat_cnt == BW'(LIMIT - 1)));

    // While granted, the search already starts after the current holder so a
    // release can re-grant at the same edge without a bubble.
    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req  (req_valid),
        .i_last (grant_valid ? r_grant_id : r_last),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_last_nxt     = r_last;
        w_beat_cnt_nxt = r_beat_cnt;
        if (r_state == IDLE) begin
            if (w_pick_any) begin
                w_state_nxt    = GRANT;
                w_grant_id_nxt = w_pick_idx;
                w_beat_cnt_nxt = '0;
            end
        end else if (w_release) begin
            w_last_nxt     = r_grant_id;
            w_beat_cnt_nxt = '0;
            w_state_nxt    = w_pick_any ? GRANT : IDLE;
            w_grant_id_nxt = w_pick_any ? w_pick_idx : r_grant_id;
        end else if (fifo_wen) begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant_id <= '0;
            r_last     <= IW'(NREQ - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_afifo_wr_arb.sv
// tb_afifo_wr_arb: table vectors, directed corner sequences and random traffic
// checked against a cycle-level round-robin reference model.
module tb_afifo_wr_arb;
`ifdef AFIFO_WR_ARB_BURST_EN
    localparam int LIMIT = 4;
`else
    localparam int LIMIT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic        fifo_full = 1'b0;
    logic [3:0]  req_ready;
    logic        fifo_wen;
    logic [7:0]  fifo_wdata;
    logic        grant_valid;
    logic [1:0]  grant_id;

    always #5 clk = ~clk;

    afifo_wr_arb #(.DSIZE(8), .NREQ(4), .MAX_BURST(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wen    (fifo_wen),
        .fifo_wdata  (fifo_wdata),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    int errors = 0;
    int checks = 0;

    bit         m_granted;
    int         m_gid, m_beats, m_last;
    logic       e_gv, e_wen;
    logic [1:0] e_gid;
    logic [3:0] e_ready;
    logic [7:0] e_wdata;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic        f;
        logic        gv;
        logic [1:0]  gid;
        logic [3:0]  rdy;
        logic        wen;
        logic [7:0]  wd;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int next_after(input int last, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_granted = 0;
        m_gid     = 0;
        m_beats   = 0;
        m_last    = 3;
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic f);
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        fifo_full = f;
        #1;
        e_gv    = m_granted;
        e_gid   = m_gid[1:0];
        e_ready = (m_granted && !f) ? 4'(1 << m_gid) : 4'b0;
        e_wen   = |(v & e_ready);
        e_wdata = d[m_gid*8 +: 8];
    endtask

    task automatic step_edge();
        @(posedge clk);
        if (!m_granted) begin
            if (req_valid != 0) begin
                m_gid     = next_after(m_last, req_valid);
                m_granted = 1;
                m_beats   = 0;
            end
        end else begin
            if (e_wen) m_beats++;
            if (!req_valid[m_gid] || (e_wen && m_beats == LIMIT)) begin
                m_last  = m_gid;
                m_beats = 0;
                if (req_valid != 0) m_gid = next_after(m_last, req_valid);
                else m_granted = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_gv"}, grant_valid, e_gv);
        chk({tag, "_ready"}, req_ready, e_ready);
        chk({tag, "_wen"}, fifo_wen, e_wen);
        if (e_gv) chk({tag, "_gid"}, grant_id, e_gid);
        if (e_wen) chk({tag, "_wdata"}, fifo_wdata, e_wdata);
    endtask

    task automatic run_cycle(input logic [3:0] v, input logic [31:0] d, input logic f, input string tag);
        drive(v, d, f);
        check_model(tag);
        step_edge();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_gv", grant_valid, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wen", fifo_wen, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] pend, acc;
        logic [7:0] dat[4];
        int e;
        model_reset();
        tbl[0]  = '{4'b0010, 32'h00005A00, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[1]  = '{4'b0010, 32'h00005A00, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 8'h5A};
        tbl[2]  = '{4'b0000, 32'h00005A00, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 8'h5A};
        tbl[3]  = '{4'b0000, 32'h00005A00, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[4]  = '{4'b0010, 32'h0000C300, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        for (int i = 5; i <= 9; i++)
            tbl[i] = '{4'b0010, 32'h0000C300, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 8'h00};
        tbl[10] = '{4'b0010, 32'h0000C300, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hC3};
        tbl[11] = '{4'b0000, 32'h0000C300, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 8'h00};
        tbl[12] = '{4'b0000, 32'h00000000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].f);
            chk($sformatf("tbl%0d_gv", i), grant_valid, tbl[i].gv);
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_wen", i), fifo_wen, tbl[i].wen);
            if (tbl[i].gv) chk($sformatf("tbl%0d_gid", i), grant_id, tbl[i].gid);
            if (tbl[i].wen) chk($sformatf("tbl%0d_wdata", i), fifo_wdata, tbl[i].wd);
            step_edge();
        end

        // all four requesters streaming
        do_reset();
        for (int n = 0; n < 13; n++) begin
            drive(4'b1111, 32'h44332211, 1'b0);
            if (n == 0) chk("t2_bubble", grant_valid, 0);
            else begin
                e = ((n - 1) / LIMIT) % 4;
                chk($sformatf("t2_gid%0d", n), grant_id, e);
                chk($sformatf("t2_wen%0d", n), fifo_wen, 1);
                chk($sformatf("t2_wdata%0d", n), fifo_wdata, 8'(8'h11 * (e + 1)));
            end
            step_edge();
        end

        // requesters 0 and 2 alternate without bubbles
        do_reset();
        for (int n = 0; n < 18; n++) begin
            drive(4'b0101, 32'h00CC00AA, 1'b0);
            if (n == 0) chk("t3_bubble", grant_valid, 0);
            else begin
                e = (((n - 1) / LIMIT) % 2) * 2;
                chk($sformatf("t3_gid%0d", n), grant_id, e);
                chk($sformatf("t3_wen%0d", n), fifo_wen, 1);
                chk($sformatf("t3_wdata%0d", n), fifo_wdata, (e == 0) ? 8'hAA : 8'hCC);
            end
            step_edge();
        end

        // requester 3 abandons its burst while 1 waits
        do_reset();
        run_cycle(4'b1000, 32'hDD00BB00, 1'b0, "t5a");
        run_cycle(4'b1010, 32'hDD00BB00, 1'b0, "t5b");
        run_cycle(4'b1010, 32'hDD00BB00, 1'b0, "t5c");
        run_cycle(4'b0010, 32'hDD00BB00, 1'b0, "t5d");
        for (int n = 0; n < 4; n++) begin
            drive(4'b0010, 32'hDD00BB00, 1'b0);
            check_model("t5e");
            chk("t5_owner", grant_id, 1);
            step_edge();
        end

        // asynchronous reset in the middle of a burst
        do_reset();
        for (int n = 0; n < 3; n++) run_cycle(4'b1111, 32'h44332211, 1'b0, "t6a");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_gv", grant_valid, 0);
        chk("t6_wen", fifo_wen, 0);
        chk("t6_ready", req_ready, 0);
        chk("t6_gid", grant_id, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 4; n++) begin
            drive(4'b1111, 32'h44332211, 1'b0);
            check_model("t6b");
            if (n == 1) chk("t6_first", grant_id, 0);
            step_edge();
        end

        // random traffic with random backpressure
        do_reset();
        pend = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++)
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    dat[i]  = 8'($urandom);
                end
            drive(pend, {dat[3], dat[2], dat[1], dat[0]}, $urandom_range(0, 3) == 0);
            check_model("rnd");
            acc = pend & e_ready;
            step_edge();
            pend = pend & ~acc;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
